// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller sitting at the M stage.
// Holds SR, Cause, EPC and PrID. Serves mfc0 reads and mtc0 writes, handles
// eret, and raises IntReq so the pipeline flushes and fetch jumps to ExcPC.
module cp0_unit #(
  parameter logic [31:0] PRID      = 32'h0000_2019,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD_in,
  input  logic [4:0]  ExcCode_in,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPC_out,
  output logic [31:0] ExcPC,
  output logic        IntReq
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  // EPC, bits [1:0] are kept at zero on every write path
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Return address of the victim: a delay-slot victim restarts at its branch.
  // Wraps modulo 2^32 and is forced word-aligned.
  function automatic logic [31:0] victim_epc(input logic [31:0] pc,
                                             input logic        in_slot);
    logic [31:0] ret;
    ret = in_slot ? (pc - 32'd4) : pc;
    return ret & ~32'h3;
  endfunction

  assign sr_word    = {16'b0, im, 8'b0, exl, ie};
  assign cause_word = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

  // Request decode; EXL masks both sources so handlers never nest
  always_comb begin
    int_req = (|(HWInt & im)) & ie & ~exl;
    exc_req = (ExcCode_in != 5'd0) & ~exl;
    IntReq  = int_req | exc_req;
  end

  // mfc0 read port, shows state before any write landing this cycle
  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

  assign EPC_out = epc;
  assign ExcPC   = EXC_ENTRY;

  // State update: exception entry beats eret, eret beats plain mtc0;
  // IP samples the interrupt lines every cycle regardless.
  always_ff @(posedge clk) begin
    if (!reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        // Victim is flushed, so its mtc0 and eret never take effect
        exl      <= 1'b1;
        exc_code <= int_req ? 5'd0 : ExcCode_in;
        bd       <= BD_in;
        epc      <= victim_epc(PC, BD_in);
      end else begin
        if (EXLClr) exl <= 1'b0;
        if (WE) begin
          case (A2)
            REG_SR: begin
              im <= DIn[15:10];
              ie <= DIn[0];
              // eret keeps EXL cleared even when SR is rewritten alongside it
              if (!EXLClr) exl <= DIn[1];
            end
            REG_EPC: epc <= DIn & ~32'h3;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit with hand-computed expected values.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BD_in;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] DOut;
  logic [31:0] EPC_out;
  logic [31:0] ExcPC;
  logic        IntReq;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_unit dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .PC        (PC),
    .BD_in     (BD_in),
    .ExcCode_in(ExcCode_in),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .DOut      (DOut),
    .EPC_out   (EPC_out),
    .ExcPC     (ExcPC),
    .IntReq    (IntReq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    A1 = idx;
    #1;
    chk(tag, DOut, exp);
  endtask

  initial begin
    reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0;
    PC = 32'd0; BD_in = 1'b0; ExcCode_in = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;

    // 1: reset values
    tick();
    reset = 1'b1;
    rd("rst_sr",    5'd12, 32'h0000_0000);
    rd("rst_cause", 5'd13, 32'h0000_0000);
    rd("rst_epc",   5'd14, 32'h0000_0000);
    rd("rst_prid",  5'd15, 32'h0000_2019);
    rd("rst_unimp", 5'd7,  32'h0000_0000);
    chk("rst_intreq", {31'd0, IntReq}, 32'd0);
    chk("excpc", ExcPC, 32'h0000_4180);

    // 2: overflow exception, then a second one masked by EXL
    ExcCode_in = 5'd12; PC = 32'h3008; BD_in = 1'b0;
    #1 chk("ov_intreq", {31'd0, IntReq}, 32'd1);
    tick();
    ExcCode_in = 5'd0;
    rd("ov_cause", 5'd13, 32'h0000_0030);
    rd("ov_sr",    5'd12, 32'h0000_0002);
    chk("ov_epc", EPC_out, 32'h0000_3008);
    ExcCode_in = 5'd12; PC = 32'h5000;
    #1 chk("ov_nested_intreq", {31'd0, IntReq}, 32'd0);
    tick();
    ExcCode_in = 5'd0;
    chk("ov_epc_frozen", EPC_out, 32'h0000_3008);
    // eret
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_0000);

    // 3: enable interrupts, HW interrupt beats RI; flushed mtc0/eret dropped
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
    tick();
    WE = 1'b0;
    rd("mtc0_sr", 5'd12, 32'h0000_FC01);
    HWInt = 6'b000100; ExcCode_in = 5'd10; PC = 32'h4000;
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_1234; EXLClr = 1'b1;
    #1 chk("int_intreq", {31'd0, IntReq}, 32'd1);
    tick();
    WE = 1'b0; EXLClr = 1'b0; ExcCode_in = 5'd0;
    rd("int_cause", 5'd13, 32'h0000_1000);
    rd("int_sr",    5'd12, 32'h0000_FC03);
    chk("int_epc", EPC_out, 32'h0000_4000);
    HWInt = 6'd0;
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd("int_ip_clear", 5'd13, 32'h0000_0000);
    // disable interrupts again; write is not visible until next cycle
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0000; A1 = 5'd12;
    #1 chk("no_writethrough", DOut, 32'h0000_FC01);
    tick();
    // writes to Cause / PrID are ignored
    A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    A2 = 5'd15;
    tick();
    WE = 1'b0;
    rd("cause_ro", 5'd13, 32'h0000_0000);
    rd("prid_ro",  5'd15, 32'h0000_2019);
    rd("sr_off",   5'd12, 32'h0000_0000);

    // 4: AdEL in a delay slot
    BD_in = 1'b1; PC = 32'h3010; ExcCode_in = 5'd4;
    tick();
    BD_in = 1'b0; ExcCode_in = 5'd0;
    chk("bd_epc", EPC_out, 32'h0000_300C);
    rd("bd_cause", 5'd13, 32'h8000_0010);

    // 5: eret together with mtc0 to EPC
    EXLClr = 1'b1; WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3403;
    tick();
    EXLClr = 1'b0; WE = 1'b0;
    chk("eret_mtc0_epc", EPC_out, 32'h0000_3400);
    rd("eret_mtc0_sr", 5'd12, 32'h0000_0000);

    // EPC wrap and eret together with an SR write
    BD_in = 1'b1; PC = 32'h0000_0000; ExcCode_in = 5'd5;
    tick();
    BD_in = 1'b0; ExcCode_in = 5'd0;
    chk("wrap_epc", EPC_out, 32'hFFFF_FFFC);
    rd("ades_cause", 5'd13, 32'h8000_0014);
    EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403;
    tick();
    EXLClr = 1'b0; WE = 1'b0;
    rd("eret_sr_write", 5'd12, 32'h0000_0401);
    // interrupt mask
    HWInt = 6'b000010;
    #1 chk("masked_int", {31'd0, IntReq}, 32'd0);
    HWInt = 6'b000001;
    #1 chk("unmasked_int", {31'd0, IntReq}, 32'd1);

    // 6: reset wins over a pending request
    reset = 1'b0; ExcCode_in = 5'd10; PC = 32'h7000;
    #1 chk("rst_cycle_intreq", {31'd0, IntReq}, 32'd1);
    tick();
    reset = 1'b1; HWInt = 6'd0; ExcCode_in = 5'd0;
    rd("rst2_sr",    5'd12, 32'h0000_0000);
    rd("rst2_cause", 5'd13, 32'h0000_0000);
    chk("rst2_epc", EPC_out, 32'h0000_0000);
    chk("rst2_intreq", {31'd0, IntReq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
